// File: rtl/regfile_pkg.sv
// Shared constants, types and the write-port arbitration helper for the
// multi-port integer register file.
package regfile_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;
  localparam int DEF_AW    = $clog2(DEF_NREGS);

  // Upper bound on write ports understood by the arbitration helper.
  localparam int MAX_WR = 32;

  typedef logic [DEF_AW-1:0]   addr_t;
  typedef logic [DEF_XLEN-1:0] data_t;

  // Returns the highest-index set bit of a write-hit vector, or -1 if none.
  // Higher-index write ports take priority when several target one register.
  function automatic int win_port(input logic [MAX_WR-1:0] hits);
    int w;
    w = -1;
    for (int p = 0; p < MAX_WR; p++) begin
      if (hits[p]) w = p;
    end
    return w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: multi-cycle producers reserve their destination at
// issue; a write releases it, a flush clears everything.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS    = DEF_NREGS,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1,
  parameter int AW       = $clog2(NREGS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_WR-1:0]            wr_en_i,
  input  logic [NUM_WR-1:0][AW-1:0]    wr_addr_i,
  input  logic                         rsv_en_i,
  input  logic [AW-1:0]                rsv_addr_i,
  input  logic                         flush_i,
  input  logic [NUM_RD-1:0][AW-1:0]    rd_addr_i,
  output logic [NUM_RD-1:0]            busy_o
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Next busy state: writes clear, then flush or reserve; a reserve applied
  // after the clear lets it win over a same-cycle write to that register.
  always_comb begin
    busy_d = busy_q;
    for (int p = 0; p < NUM_WR; p++) begin
      if (wr_en_i[p]) busy_d[wr_addr_i[p]] = 1'b0;
    end
    if (flush_i) begin
      busy_d = '0;
    end else if (rsv_en_i) begin
      busy_d[rsv_addr_i] = 1'b1;
    end
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  // Busy register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_lookup
      assign busy_o[gi] = busy_q[rd_addr_i[gi]];
    end
  endgenerate

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file: data array, write arbitration,
// optional write-to-read bypass, and a busy scoreboard for reservations.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = DEF_XLEN,
  parameter int NREGS    = DEF_NREGS,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int AW       = $clog2(NREGS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_RD-1:0][AW-1:0]     rd_addr_i,
  output logic [NUM_RD-1:0][XLEN-1:0]   rd_data_o,
  output logic [NUM_RD-1:0]             rd_busy_o,
  input  logic [NUM_WR-1:0]             wr_en_i,
  input  logic [NUM_WR-1:0][AW-1:0]     wr_addr_i,
  input  logic [NUM_WR-1:0][XLEN-1:0]   wr_data_i,
  input  logic                          rsv_en_i,
  input  logic [AW-1:0]                 rsv_addr_i,
  input  logic                          flush_i
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [NUM_RD-1:0] sb_busy;

  // Next array contents: ports applied in ascending order so the highest
  // index wins a conflict; register 0 is hardwired when ZERO_REG is set.
  always_comb begin
    regs_d = regs_q;
    for (int p = 0; p < NUM_WR; p++) begin
      if (wr_en_i[p] && !(ZERO_REG != 0 && wr_addr_i[p] == '0)) begin
        regs_d[wr_addr_i[p]] = wr_data_i[p];
      end
    end
  end

  // Data array with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .NUM_RD   (NUM_RD),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (wr_en_i),
    .wr_addr_i  (wr_addr_i),
    .rsv_en_i   (rsv_en_i),
    .rsv_addr_i (rsv_addr_i),
    .flush_i    (flush_i),
    .rd_addr_i  (rd_addr_i),
    .busy_o     (sb_busy)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [MAX_WR-1:0] hit_vec;
      int                win;
      logic [XLEN-1:0]   byp_data;
      logic [XLEN-1:0]   data_l;
      logic              busy_l;

      // Read mux: forward the winning same-cycle write (suppressed while in
      // reset so outputs stay zero), otherwise the stored value and busy bit.
      always_comb begin
        hit_vec = '0;
        for (int p = 0; p < NUM_WR; p++) begin
          hit_vec[p] = wr_en_i[p] && (wr_addr_i[p] == rd_addr_i[gi]) &&
                       !(ZERO_REG != 0 && rd_addr_i[gi] == '0);
        end
        win      = win_port(hit_vec);
        byp_data = '0;
        for (int p = 0; p < NUM_WR; p++) begin
          if (p == win) byp_data = wr_data_i[p];
        end
        data_l = regs_q[rd_addr_i[gi]];
        busy_l = sb_busy[gi];
        if (BYPASS != 0 && !rst && win >= 0) begin
          data_l = byp_data;
          busy_l = 1'b0;
        end
      end

      assign rd_data_o[gi] = data_l;
      assign rd_busy_o[gi] = busy_l;
    end
  endgenerate

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the RISC-V core, successor to the fixed 2-read/1-write register file. It adds configurable width, depth and port counts, optional write-to-read bypass, a synchronous flush, and a per-register busy scoreboard so a multi-cycle producer can reserve its destination at issue. It sits between decode (read addresses, reservations) and writeback (write ports).

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (power of two, ≥2)
- NUM_RD, 2, number of read ports
- NUM_WR, 2, number of write ports
- ZERO_REG, 1, when 1 register 0 reads 0, ignores writes, and is never busy
- BYPASS, 1, when 1 same-cycle write data is forwarded to matching reads
- AW, $clog2(NREGS), address width (derived; do not override)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- rd_addr_i  in  NUM_RD×AW  read addresses
- rd_data_o  out  NUM_RD×XLEN  read data (combinational)
- rd_busy_o  out  NUM_RD  addressed register has a pending reservation
- wr_en_i  in  NUM_WR  write enables
- wr_addr_i  in  NUM_WR×AW  write addresses
- wr_data_i  in  NUM_WR×XLEN  write data
- rsv_en_i  in  1  reserve (mark busy) rsv_addr_i
- rsv_addr_i  in  AW  register to reserve
- flush_i  in  1  clear all busy bits (pipeline flush); data untouched

## Operation
- Storage: NREGS×XLEN array plus NREGS busy bits.
- Reset (async assert): all registers 0, all busy bits 0; therefore every rd_data_o = 0 and every rd_busy_o = 0 while rst is high.
- Write: on clk edge, each port with wr_en_i=1 writes wr_data_i to wr_addr_i and clears that register's busy bit.
- Write conflict: several ports to the same address in one cycle → highest-index port wins (data and forwarding).
- Zero register (ZERO_REG=1): writes to address 0 discarded; reads of 0 return 0; rsv to 0 ignored; rd_busy_o for address 0 always 0.
- Reserve: rsv_en_i=1 sets busy[rsv_addr_i] at the edge.
- Same-cycle reserve and write to same address: reserve wins → busy=1 after edge, data updated.
- flush_i=1: all busy bits 0 after edge; a same-cycle rsv_en_i is ignored; writes proceed normally.
- Read: rd_data_o[k] = array[rd_addr_i[k]]; rd_busy_o[k] = busy[rd_addr_i[k]].
- Bypass (BYPASS=1): if any enabled write port targets rd_addr_i[k] this cycle (and address ≠0 when ZERO_REG), rd_data_o[k] = winning port's wr_data_i and rd_busy_o[k] = 0. With BYPASS=0, reads return pre-edge array contents and busy.
- Out-of-range addresses cannot occur (NREGS is power of two).

## Timing
- Read latency: 0 cycles (combinational from addresses and state).
- Write visible through array 1 cycle after edge; through bypass same cycle.
- Busy set/clear takes effect at the edge; rd_busy_o reflects new value the following cycle.
- Reset deassertion: first write/reserve takes effect on the first rising edge with rst low.
- Reset asserted mid-cycle: state clears immediately, independent of clk; pending writes in that cycle lost.

## Structure
- Package regfile_pkg: default XLEN/NREGS constants, addr_t/data_t typedefs, function for winning write-port index.
- Sub-module regfile_scoreboard: busy-bit vector with reserve/clear/flush logic and NUM_RD busy lookups; top holds data array, write arbitration, bypass muxes.

## Test plan
- Reset: assert rst with all inputs random → all rd_data_o=0, rd_busy_o=0; release, read x5 → 0.
- Write/read: wr port0 x5=0xDEADBEEF, next cycle read port1 x5 → 0xDEADBEEF; write x0=0x1234 → reads 0.
- Conflict + bypass: same cycle port0 x7=0x11, port1 x7=0x22, read x7 → 0x22 same cycle (BYPASS=1) and 0x22 next cycle; BYPASS=0 build → old value same cycle.
- Scoreboard: rsv x3 → next cycle rd_busy=1; write x3=0x55 → bypass cycle busy=0, data 0x55; reserve+write x3 together → busy=1 after edge, data 0x55.
- Flush: reserve x1,x2,x4 over three cycles, then flush_i with rsv x6 → all busy 0 including x6; data unchanged.
- Async reset mid-op: registers loaded, rst pulsed between edges → outputs 0 immediately, busy cleared.
